// File: rtl/if_fetch_unit_if.sv
// Wishbone classic instruction-fetch bus between the fetch stage and instruction memory.
interface if_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [3:0]            wb_sel_o;
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic                  wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a Wishbone classic read master and
// presents the fetched instruction to IF/ID with a valid/stall handshake.
module if_fetch_unit #(
    parameter logic [31:0] PC_ADDR    = 32'h8000_0000,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            ifid_stall_and_flush,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    if_fetch_unit_if.master       wb,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_inst,
    output logic                  if_valid,
    output logic                  im_busy
);
    typedef enum logic [1:0] {START, FETCH, HOLD} state_e;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(PC_ADDR);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_adr_q, req_adr_d;
    logic [DATA_WIDTH-1:0] inst_buf_q, inst_buf_d;
    logic                  discard_q, discard_d;

    logic                  stall;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] seq_adr;

    assign stall   = ifid_stall_and_flush[0];
    assign flush   = ifid_stall_and_flush[1];
    assign target  = branch_target & ~ADDR_WIDTH'(3);
    assign seq_adr = req_adr_q + ADDR_WIDTH'(4);

    // Outputs decode from registered state only.
    assign wb.wb_cyc_o = (state_q == FETCH);
    assign wb.wb_stb_o = (state_q == FETCH);
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_sel_o = 4'hF;
    assign wb.wb_adr_o = req_adr_q;
    assign if_pc       = req_adr_q;
    assign if_inst     = inst_buf_q;
    assign if_valid    = (state_q == HOLD);
    assign im_busy     = (state_q != HOLD);

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= START;
            pc_q       <= RESET_PC;
            req_adr_q  <= RESET_PC;
            inst_buf_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_adr_q  <= req_adr_d;
            inst_buf_q <= inst_buf_d;
            discard_q  <= discard_d;
        end
    end

    // Next-state logic: fetch sequencing, redirect and handoff.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_adr_d  = req_adr_q;
        inst_buf_d = inst_buf_q;
        discard_d  = discard_q;
        unique case (state_q)
            START: begin
                req_adr_d = pc_q;
                state_d   = FETCH;
            end
            FETCH: begin
                if (branch_taken) begin
                    pc_d = target;
                    if (wb.wb_ack_i) begin
                        // Data for the old path is dropped; restart at target at once.
                        req_adr_d = target;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (wb.wb_ack_i) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        req_adr_d = pc_q;
                    end else begin
                        inst_buf_d = wb.wb_dat_i;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_d      = target;
                    req_adr_d = target;
                    discard_d = 1'b0;
                    state_d   = FETCH;
                end else if (flush || !stall) begin
                    pc_d      = seq_adr;
                    req_adr_d = seq_adr;
                    state_d   = FETCH;
                end
            end
            default: state_d = START;
        endcase
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit with a delivery scoreboard.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ifid_stall_and_flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        im_busy;

    if_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

    if_fetch_unit #(
        .PC_ADDR   (32'h8000_0000),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .ifid_stall_and_flush(ifid_stall_and_flush),
        .branch_taken        (branch_taken),
        .branch_target       (branch_target),
        .wb                  (wb.master),
        .if_pc               (if_pc),
        .if_inst             (if_inst),
        .if_valid            (if_valid),
        .im_busy             (im_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } deliv_t;

    deliv_t exp_q[$];
    int     n_vec = 0;
    int     n_err = 0;
    logic   prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] adr);
        chk({tag, ".cyc"}, 32'(wb.wb_cyc_o), 32'd1);
        chk({tag, ".stb"}, 32'(wb.wb_stb_o), 32'd1);
        chk({tag, ".adr"}, wb.wb_adr_o, adr);
        chk({tag, ".valid"}, 32'(if_valid), 32'd0);
        chk({tag, ".busy"}, 32'(im_busy), 32'd1);
    endtask

    task automatic chk_hold(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".cyc"}, 32'(wb.wb_cyc_o), 32'd0);
        chk({tag, ".valid"}, 32'(if_valid), 32'd1);
        chk({tag, ".busy"}, 32'(im_busy), 32'd0);
        chk({tag, ".pc"}, if_pc, pc);
        chk({tag, ".inst"}, if_inst, inst);
    endtask

    // Hold the bus for `waits` wait states at `adr`, then ack with `dat`.
    // A delivery is expected only when `keep` is set.
    task automatic mem_ack(input string tag, input int waits, input logic [31:0] adr,
                           input logic [31:0] dat, input logic keep);
        for (int i = 0; i < waits; i++) begin
            chk_fetch({tag, ".ws"}, adr);
            tick();
        end
        chk_fetch({tag, ".ack"}, adr);
        if (keep) exp_q.push_back('{pc: adr, inst: dat});
        wb.wb_ack_i = 1'b1;
        wb.wb_dat_i = dat;
        tick();
        wb.wb_ack_i = 1'b0;
        wb.wb_dat_i = '0;
    endtask

    // Scoreboard: each new presentation must match the oldest expected delivery.
    always @(negedge clk) begin
        if (if_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb.unexpected", if_pc, 32'hxxxx_xxxx);
            end else begin
                chk("sb.pc", if_pc, exp_q[0].pc);
                chk("sb.inst", if_inst, exp_q[0].inst);
                void'(exp_q.pop_front());
            end
        end
        prev_valid <= if_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                = 1'b1;
        ifid_stall_and_flush = 2'b00;
        branch_taken         = 1'b0;
        branch_target        = '0;
        wb.wb_ack_i          = 1'b0;
        wb.wb_dat_i          = '0;
        tick();
        tick();
        chk("rst.cyc", 32'(wb.wb_cyc_o), 32'd0);
        chk("rst.adr", wb.wb_adr_o, 32'h8000_0000);
        chk("rst.valid", 32'(if_valid), 32'd0);
        chk("rst.inst", if_inst, 32'd0);
        chk("rst.pc", if_pc, 32'h8000_0000);
        chk("rst.busy", 32'(im_busy), 32'd1);

        // 1/2: first fetch, then stall in HOLD for three cycles
        reset = 1'b0;
        chk("start.cyc", 32'(wb.wb_cyc_o), 32'd0);
        chk("start.busy", 32'(im_busy), 32'd1);
        tick();
        ifid_stall_and_flush = 2'b01;
        mem_ack("t1", 2, 32'h8000_0000, 32'h0000_0013, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk_hold("t2.stall", 32'h8000_0000, 32'h0000_0013);
            tick();
        end
        chk_hold("t2.last", 32'h8000_0000, 32'h0000_0013);
        ifid_stall_and_flush = 2'b00;
        tick();
        chk_fetch("t2.next", 32'h8000_0004);

        // 3: redirect while a fetch is outstanding, late ack dropped
        branch_taken  = 1'b1;
        branch_target = 32'h8000_0100;
        tick();
        branch_taken = 1'b0;
        mem_ack("t3", 2, 32'h8000_0004, 32'hBAD0_0004, 1'b0);
        chk_fetch("t3.redir", 32'h8000_0100);

        // 4: redirect coinciding with ack
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h8000_0200;
        mem_ack("t4", 0, 32'h8000_0100, 32'hBAD0_0100, 1'b0);
        branch_taken = 1'b0;
        chk_fetch("t4.redir", 32'h8000_0200);
        ifid_stall_and_flush = 2'b01;
        mem_ack("t4.fetch", 1, 32'h8000_0200, 32'h1111_2222, 1'b1);
        chk_hold("t4.hold", 32'h8000_0200, 32'h1111_2222);

        // 5: branch wins over stall and flush in HOLD; low target bits ignored
        ifid_stall_and_flush = 2'b11;
        branch_taken         = 1'b1;
        branch_target        = 32'h8000_0302;
        tick();
        branch_taken         = 1'b0;
        ifid_stall_and_flush = 2'b00;
        chk_fetch("t5.redir", 32'h8000_0300);
        mem_ack("t5.fetch", 0, 32'h8000_0300, 32'h3333_4444, 1'b1);
        chk_hold("t5.hold", 32'h8000_0300, 32'h3333_4444);
        tick();
        ifid_stall_and_flush = 2'b01;
        mem_ack("t5.seq", 1, 32'h8000_0304, 32'h5555_6666, 1'b1);
        chk_hold("t5.held", 32'h8000_0304, 32'h5555_6666);
        ifid_stall_and_flush = 2'b11;
        tick();
        ifid_stall_and_flush = 2'b00;
        chk_fetch("t5.flush", 32'h8000_0308);

        // 6: PC wrap at top of address space
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        mem_ack("t6.br", 0, 32'h8000_0308, 32'hBAD0_0308, 1'b0);
        branch_taken = 1'b0;
        mem_ack("t6.top", 0, 32'hFFFF_FFFC, 32'h7777_8888, 1'b1);
        chk_hold("t6.hold", 32'hFFFF_FFFC, 32'h7777_8888);
        tick();
        chk_fetch("t6.wrap", 32'h0000_0000);

        // 6: reset mid-fetch, late ack ignored outside FETCH
        tick();
        reset = 1'b1;
        #1;
        chk("t6.rst.cyc", 32'(wb.wb_cyc_o), 32'd0);
        chk("t6.rst.adr", wb.wb_adr_o, 32'h8000_0000);
        chk("t6.rst.busy", 32'(im_busy), 32'd1);
        wb.wb_ack_i = 1'b1;
        wb.wb_dat_i = 32'hDEAD_BEEF;
        tick();
        reset = 1'b0;
        tick();
        wb.wb_ack_i = 1'b0;
        wb.wb_dat_i = '0;
        chk_fetch("t6.refetch", 32'h8000_0000);
        tick();
        mem_ack("t6.post", 0, 32'h8000_0000, 32'h9999_AAAA, 1'b1);
        chk_hold("t6.post.hold", 32'h8000_0000, 32'h9999_AAAA);
        tick();
        chk("sb.drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
